// File: rtl/jtframe_layer_mix.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_layer_mix
//  Purpose  : Parametrised colour mixer. Selects the highest-priority opaque
//             layer per pixel using a run-time priority order and per-layer
//             enables, looks the result up in a CPU-writable BGR555 palette
//             and outputs 5-bit RGB with blanking delayed to match.
//  Ports    : clk, rst (async, active high), pxl_cen, cpu_cen
//             LHBL/LVBL in, LHBL_dly/LVBL_dly out (3 pxl_cen delay)
//             pal_cs, cpu_rnw, cpu_addr, cpu_dout -> pal_dout (CPU port)
//             pxl_in, prio_order, gfx_en -> red, green, blue (video path)
//  Revision : 1.0  initial release
// ============================================================================
module jtframe_layer_mix #(
    parameter int LAYERS = 2,
    parameter int LW     = 1,
    parameter int PXLW   = 7,
    parameter int PALW   = LW + PXLW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen,
    input  logic                   cpu_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    input  logic                   pal_cs,
    input  logic                   cpu_rnw,
    input  logic [PALW:0]          cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    input  logic [LAYERS*PXLW-1:0] pxl_in,
    input  logic [LAYERS*LW-1:0]   prio_order,
    input  logic [LAYERS-1:0]      gfx_en,
    output logic [4:0]             red,
    output logic [4:0]             green,
    output logic [4:0]             blue
);

    localparam int c_ENTRIES = 2**PALW;

    // Palette split into byte lanes so a CPU access writes a single byte.
    logic [7:0] r_pal_lo [c_ENTRIES];
    logic [7:0] r_pal_hi [c_ENTRIES];

    logic            w_cpu_we;
    logic [PALW-1:0] w_cpu_entry;

    assign w_cpu_we    = pal_cs & ~cpu_rnw & cpu_cen;
    assign w_cpu_entry = cpu_addr[PALW:1];

    // S1 registers
    logic [LAYERS*PXLW-1:0] r_pxl;
    logic [LAYERS*LW-1:0]   r_prio;
    logic [LAYERS-1:0]      r_en;
    logic                   r_hb1;
    logic                   r_vb1;
    // S2 registers
    logic [PALW-1:0]        r_idx;
    logic                   r_hb2;
    logic                   r_vb2;
    // S3 register
    logic [15:0]            r_vid_data;

    logic [PALW-1:0]        w_idx;
    logic                   w_found;
    logic                   w_vis;

    // Priority scan. The inner loop matches a field against each real layer,
    // so a field value >= LAYERS never matches and is skipped naturally.
    // Default is the backdrop: last priority field with colour 0.
    always_comb begin
        w_found = 1'b0;
        w_idx   = PALW'({r_prio[(LAYERS-1)*LW +: LW], {PXLW{1'b0}}});
        for (int f = 0; f < LAYERS; f++) begin
            for (int l = 0; l < LAYERS; l++) begin
                if (!w_found && (r_prio[f*LW +: LW] == LW'(l)) && r_en[l]
                    && (r_pxl[l*PXLW +: 4] != 4'd0)) begin
                    w_found = 1'b1;
                    w_idx   = PALW'({LW'(l), r_pxl[l*PXLW +: PXLW]});
                end
            end
        end
    end

    // Palette storage has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_cpu_we) begin
            if (cpu_addr[0]) begin
                r_pal_hi[w_cpu_entry] <= cpu_dout;
            end else begin
                r_pal_lo[w_cpu_entry] <= cpu_dout;
            end
        end
    end

    // Video pipeline and CPU read port. The S3 read samples the arrays in the
    // same edge as a CPU write, so a colliding pixel sees the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pxl      <= '0;
            r_prio     <= '0;
            r_en       <= '0;
            r_hb1      <= 1'b0;
            r_vb1      <= 1'b0;
            r_idx      <= '0;
            r_hb2      <= 1'b0;
            r_vb2      <= 1'b0;
            r_vid_data <= '0;
            LHBL_dly   <= 1'b0;
            LVBL_dly   <= 1'b0;
            pal_dout   <= 8'd0;
        end else begin
            if (pxl_cen) begin
                r_pxl      <= pxl_in;
                r_prio     <= prio_order;
                r_en       <= gfx_en;
                r_hb1      <= LHBL;
                r_vb1      <= LVBL;
                r_idx      <= w_idx;
                r_hb2      <= r_hb1;
                r_vb2      <= r_vb1;
                r_vid_data <= {r_pal_hi[r_idx], r_pal_lo[r_idx]};
                LHBL_dly   <= r_hb2;
                LVBL_dly   <= r_vb2;
            end
            if (pal_cs && cpu_rnw) begin
                pal_dout <= cpu_addr[0] ? r_pal_hi[w_cpu_entry] : r_pal_lo[w_cpu_entry];
            end
        end
    end

    // Entry layout: low byte {G[2:0],R}, high byte {x,B,G[4:3]}.
    assign w_vis = LHBL_dly & LVBL_dly;
    assign red   = w_vis ? r_vid_data[4:0]                     : 5'd0;
    assign green = w_vis ? {r_vid_data[9:8], r_vid_data[7:5]}  : 5'd0;
    assign blue  = w_vis ? r_vid_data[14:10]                   : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_layer_mix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtframe_layer_mix
//  Purpose  : Self-checking bench for jtframe_layer_mix (LAYERS=2) using a
//             byte-array palette model and a queue of pixels in flight.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtframe_layer_mix;

    localparam int LAYERS = 2;
    localparam int LW     = 1;
    localparam int PXLW   = 7;
    localparam int PALW   = LW + PXLW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   pxl_cen = 1'b0;
    logic                   cpu_cen = 1'b0;
    logic                   LHBL = 1'b0;
    logic                   LVBL = 1'b0;
    logic                   LHBL_dly;
    logic                   LVBL_dly;
    logic                   pal_cs = 1'b0;
    logic                   cpu_rnw = 1'b1;
    logic [PALW:0]          cpu_addr = '0;
    logic [7:0]             cpu_dout = '0;
    logic [7:0]             pal_dout;
    logic [LAYERS*PXLW-1:0] pxl_in = '0;
    logic [LAYERS*LW-1:0]   prio_order = '0;
    logic [LAYERS-1:0]      gfx_en = '0;
    logic [4:0]             red;
    logic [4:0]             green;
    logic [4:0]             blue;

    jtframe_layer_mix #(
        .LAYERS (LAYERS),
        .LW     (LW),
        .PXLW   (PXLW),
        .PALW   (PALW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pxl_cen    (pxl_cen),
        .cpu_cen    (cpu_cen),
        .LHBL       (LHBL),
        .LVBL       (LVBL),
        .LHBL_dly   (LHBL_dly),
        .LVBL_dly   (LVBL_dly),
        .pal_cs     (pal_cs),
        .cpu_rnw    (cpu_rnw),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .pal_dout   (pal_dout),
        .pxl_in     (pxl_in),
        .prio_order (prio_order),
        .gfx_en     (gfx_en),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] idx;
        logic       hb;
        logic       vb;
    } exp_t;

    logic [7:0]  mb [512];      // palette model, byte addressed like the CPU
    exp_t        q[$];          // pixels in flight
    int          nvec = 0;
    int          nerr = 0;
    logic [14:0] last_rgb = '0;
    logic        last_hb  = 1'b0;
    logic        last_vb  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First enabled layer in priority order with a non-zero colour nibble.
    function automatic logic [7:0] ref_index(input logic [13:0] p, input logic [1:0] pr,
                                             input logic [1:0] en);
        for (int f = 0; f < LAYERS; f++) begin
            int l;
            l = int'(pr[f]);
            if (l < LAYERS && en[l] && p[l*PXLW +: 4] != 4'd0)
                return {l[0], p[l*PXLW +: PXLW]};
        end
        return {pr[LAYERS-1], 7'd0};
    endfunction

    function automatic logic [14:0] rgb_of(input logic [7:0] idx);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = mb[{idx, 1'b0}];
        hi = mb[{idx, 1'b1}];
        return {lo[4:0], hi[1:0], lo[7:5], hi[6:2]};
    endfunction

    task automatic prefill();
        q.delete();
        q.push_back('0);
        q.push_back('0);
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [7:0] d, input logic ce);
        @(negedge clk);
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = ce; cpu_addr = a; cpu_dout = d;
        @(posedge clk);
        #1;
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
        if (ce) mb[a] = d;
    endtask

    task automatic cpu_read(input logic [8:0] a);
        @(negedge clk);
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_cen = 1'b0; cpu_addr = a;
        @(posedge clk);
        #1;
        pal_cs = 1'b0;
        check("pal_dout", 32'(pal_dout), 32'(mb[a]));
    endtask

    task automatic pixel(input logic [13:0] p, input logic [1:0] pr, input logic [1:0] en,
                         input logic hb, input logic vb,
                         input logic wr, input logic [8:0] wa, input logic [7:0] wd);
        exp_t e;
        @(negedge clk);
        pxl_in = p; prio_order = pr; gfx_en = en; LHBL = hb; LVBL = vb; pxl_cen = 1'b1;
        if (wr) begin
            pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = wa; cpu_dout = wd;
        end
        q.push_back('{idx: ref_index(p, pr, en), hb: hb, vb: vb});
        e = q.pop_front();
        // colour uses the palette as it was before this edge's write
        last_rgb = (e.hb && e.vb) ? rgb_of(e.idx) : 15'd0;
        last_hb  = e.hb;
        last_vb  = e.vb;
        if (wr) mb[wa] = wd;
        @(posedge clk);
        #1;
        pxl_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
        check("rgb", 32'({red, green, blue}), 32'(last_rgb));
        check("lhbl_dly", 32'(LHBL_dly), 32'(last_hb));
        check("lvbl_dly", 32'(LVBL_dly), 32'(last_vb));
    endtask

    // Cycles without pxl_cen while inputs wiggle: everything must hold.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pxl_in = 14'($urandom); LHBL = 1'($urandom); LVBL = 1'($urandom);
            gfx_en = 2'($urandom); prio_order = 2'($urandom);
            @(posedge clk);
            #1;
            check("hold_rgb", 32'({red, green, blue}), 32'(last_rgb));
            check("hold_lhbl", 32'(LHBL_dly), 32'(last_hb));
        end
    endtask

    initial begin
        logic [13:0] p;
        logic [7:0]  old;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_lhbl", 32'(LHBL_dly), 32'd0);
        check("rst_lvbl", 32'(LVBL_dly), 32'd0);
        check("rst_pal_dout", 32'(pal_dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        LHBL = 1'b1; LVBL = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_rgb", 32'({red, green, blue}), 32'd0);
        check("idle_lhbl", 32'(LHBL_dly), 32'd0);

        // Fill the whole palette so every video index has a known value
        for (int a = 0; a < 512; a++) cpu_write(9'(a), 8'($urandom), 1'b1);

        // CPU round trip, byte lanes, read hold, cpu_cen gating
        cpu_write(9'h002, 8'h1F, 1'b1);
        cpu_write(9'h003, 8'h7C, 1'b1);
        cpu_read(9'h002);
        cpu_read(9'h003);
        cpu_write(9'h010, 8'hA5, 1'b1);
        check("pal_dout_hold", 32'(pal_dout), 32'h7C);
        cpu_write(9'h010, 8'h3C, 1'b0);     // no cpu_cen: must not land
        cpu_read(9'h010);
        cpu_read(9'h011);

        prefill();
        // Video index 1 -> R=31 G=0 B=31
        pixel({7'h00, 7'h01}, 2'b10, 2'b01, 1, 1, 0, '0, '0);
        pixel({7'h00, 7'h01}, 2'b10, 2'b01, 1, 1, 0, '0, '0);
        pixel({7'h00, 7'h01}, 2'b10, 2'b01, 1, 1, 0, '0, '0);
        check("idx1_rgb", 32'({red, green, blue}), 32'({5'd31, 5'd0, 5'd31}));

        // Priority: field0 = layer1 gives 0x93, swapped gives 0x05
        pixel({7'h13, 7'h05}, 2'b01, 2'b11, 1, 1, 0, '0, '0);
        pixel({7'h13, 7'h05}, 2'b10, 2'b11, 1, 1, 0, '0, '0);
        // Transparent nibble, disabled layer, all transparent backdrop
        pixel({7'h10, 7'h05}, 2'b01, 2'b11, 1, 1, 0, '0, '0);
        pixel({7'h13, 7'h05}, 2'b10, 2'b10, 1, 1, 0, '0, '0);
        pixel({7'h20, 7'h30}, 2'b01, 2'b11, 1, 1, 0, '0, '0);
        pixel({7'h20, 7'h30}, 2'b10, 2'b11, 1, 1, 0, '0, '0);
        // Blanking on an opaque pixel
        pixel({7'h13, 7'h05}, 2'b01, 2'b11, 0, 1, 0, '0, '0);
        pixel({7'h13, 7'h05}, 2'b01, 2'b11, 1, 0, 0, '0, '0);
        pixel({7'h13, 7'h05}, 2'b01, 2'b11, 1, 1, 0, '0, '0);
        pixel({7'h13, 7'h05}, 2'b01, 2'b11, 1, 1, 0, '0, '0);

        // Collision on entry 0x05: third pulse reads old, fourth reads new
        p = {7'h00, 7'h05};
        pixel(p, 2'b10, 2'b01, 1, 1, 0, '0, '0);
        pixel(p, 2'b10, 2'b01, 1, 1, 0, '0, '0);
        old = mb[9'h00A];
        pixel(p, 2'b10, 2'b01, 1, 1, 1, 9'h00A, ~old);
        pixel(p, 2'b10, 2'b01, 1, 1, 0, '0, '0);
        pixel(p, 2'b10, 2'b01, 1, 1, 0, '0, '0);

        // Randomised traffic with occasional stalls and CPU writes
        for (int i = 0; i < 300; i++) begin
            p = 14'($urandom);
            if ($urandom_range(0, 2) == 0) p[3:0] = 4'd0;
            if ($urandom_range(0, 2) == 0) p[10:7] = 4'd0;
            pixel(p, 2'($urandom), 2'($urandom),
                  1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 3) == 0), 9'($urandom), 8'($urandom));
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end

        // Asynchronous reset in mid-frame
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_rgb", 32'({red, green, blue}), 32'd0);
        check("midrst_lhbl", 32'(LHBL_dly), 32'd0);
        check("midrst_pal_dout", 32'(pal_dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prefill();
        last_rgb = '0; last_hb = 1'b0; last_vb = 1'b0;
        idle(2);
        for (int i = 0; i < 20; i++) begin
            pixel(14'($urandom), 2'($urandom), 2'($urandom), 1, 1, 0, '0, '0);
        end
        cpu_read(9'h0A7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtframe_layer_mix.md
Name: jtframe_layer_mix

Overview:
- Parametrised colour mixer with LAYERS tile/sprite layers, the generalised successor of the two-layer Contra mixer.
- Per pixel it selects the highest-priority opaque layer using a run-time priority order and per-layer enables.
- It looks the selected pixel up in a CPU-writable dual-port palette (BGR555, two bytes per entry) and outputs 5-bit RGB.
- LHBL/LVBL are delayed to match the pixel latency; it sits between the gfx layer engines and the video output.

Parameters:
- LAYERS, 2, number of input layers (2..4).
- LW, 1, bits to encode a layer index; must satisfy 2**LW >= LAYERS.
- PXLW, 7, pixel width per layer; the low 4 bits are the colour, 0 means transparent.
- PALW, LW+PXLW, palette entry address width. CPU byte address width is PALW+1.

Ports:
- clk  in  1  system clock (48 MHz)
- rst  in  1  asynchronous active-high reset
- pxl_cen  in  1  pixel clock enable
- cpu_cen  in  1  CPU bus clock enable
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- LHBL_dly  out  1  LHBL delayed to align with RGB
- LVBL_dly  out  1  LVBL delayed to align with RGB
- pal_cs  in  1  palette chip select
- cpu_rnw  in  1  1 = read, 0 = write
- cpu_addr  in  PALW+1  byte address; bit 0 = 0 low byte, 1 high byte
- cpu_dout  in  8  CPU write data
- pal_dout  out  8  palette read data
- pxl_in  in  LAYERS*PXLW  layer pixels; layer k occupies bits [k*PXLW +: PXLW]
- prio_order  in  LAYERS*LW  field 0 = layer index with highest priority; the last field is lowest
- gfx_en  in  LAYERS  1 = layer enabled; a disabled layer is treated as transparent
- red  out  5  red output
- green  out  5  green output
- blue  out  5  blue output

Behaviour:
- Reset, asynchronous:
  - red/green/blue, LHBL_dly, LVBL_dly, pal_dout and all pipeline registers are 0.
  - Palette RAM is not cleared.
  - A reset asserted mid-frame zeroes the outputs immediately; normal flow resumes at the first pxl_cen after release.
- Palette entry format (16 bits):
  - Low byte {G[2:0],R[4:0]}; high byte {x,B[4:0],G[4:3]}.
  - Entry address = cpu_addr[PALW:1].
- CPU write: on clk with pal_cs & ~cpu_rnw & cpu_cen, the addressed byte is written. Only one byte lane is written per access.
- CPU read: pal_dout is registered and updated every clk where pal_cs & cpu_rnw; it holds its value otherwise. Latency is 1 clk.
- Pipeline, advancing only on pxl_cen; total latency 3 pxl_cen:
  - S1: latch pxl_in, gfx_en, LHBL, LVBL.
  - S2, selection:
    - Scan prio_order fields 0..LAYERS-1 and pick the first layer L with gfx_en[L]=1 and pxl[L][3:0]!=0.
    - Palette index = {L, pxl[L]}.
    - If none qualifies, use the backdrop index {last prio_order field, PXLW'b0}.
    - A prio_order field >= LAYERS is skipped.
  - S3: palette RAM read of the index; registered data is converted to RGB.
    - If the delayed LHBL & LVBL is 0, RGB is forced to 0.
  - LHBL_dly and LVBL_dly follow LHBL and LVBL with exactly 3 pxl_cen of delay.
- Simultaneous CPU write and video read of the same entry on the same clk: video gets the old data (read-before-write). The new data is visible on the next read.
- Changes to prio_order or gfx_en take effect at the next S1 latch; there is no glitch within a pixel.
- Without pxl_cen all pipeline registers hold.

Test Plan:
- Reset: with rst=1, red/green/blue=0 and LHBL_dly=LVBL_dly=0. After release with the input pipeline idle, outputs remain 0.
- CPU palette round-trip:
  - Write addr 0x002=0x1F and 0x003=0x7C; read 0x002 → 0x1F one clk later.
  - Video index 1 then gives R=31, G=0, B=31.
- Priority (LAYERS=2):
  - layer0 pxl=0x05, layer1 pxl=0x13, prio_order={1,0} (field0=1) → index 0x93 on RGB 3 pxl_cen later.
  - Swap to prio_order={0,1} → index 0x05.
- Transparency/enable:
  - layer1 pxl=0x10 (low nibble 0) with layer0=0x05 → index 0x05.
  - gfx_en=2'b10 with both opaque → layer1 is used.
  - All transparent → backdrop {last field, 0}.
- Blanking: LHBL=0 for a pixel with opaque index → RGB 0 exactly 3 pxl_cen later, and LHBL_dly falls in the same cycle.
- Collision: CPU write to the entry the video is reading on the same clk → that pixel shows old colour, the next pixel shows new colour.
